// File: rtl/lockstep_bus_responder.sv
// rtl/lockstep_bus_responder.sv - lockstep dual-master Wishbone test RAM (optional err_cnt via LOCKSTEP_ERRCNT_EN)
module lockstep_bus_responder #(
  parameter int AW          = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] adr1,
  input  logic        cyc1,
  input  logic        stb1,
  input  logic        we1,
  input  logic [3:0]  sel1,
  input  logic [31:0] dat1,
  input  logic [31:0] adr2,
  input  logic        cyc2,
  input  logic        stb2,
  input  logic        we2,
  input  logic [3:0]  sel2,
  input  logic [31:0] dat2,
  output logic        ack_o,
  output logic [31:0] dat_o,
  output logic        fail,
  output logic [31:0] fail_adr
`ifdef LOCKSTEP_ERRCNT_EN
  ,
  output logic [15:0] err_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  localparam logic [3:0] WS_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t        state, state_nxt;
  logic [3:0]    wcnt, wcnt_nxt;
  logic          latch_en;
  logic          req1;
  logic [AW-1:0] lat_word;
  logic          lat_we;
  logic [3:0]    lat_sel;
  logic [31:0]   lat_dat;
  logic [AW-1:0] rd_word;
  logic          rd_we;
  logic          mismatch;
  logic [31:0]   mem [0:(1<<AW)-1];

  // Only CPU1 drives the access; CPU2 is observed purely for comparison.
  assign req1 = cyc1 & stb1;

  // When the access is accepted straight from IDLE the request is still live on
  // the bus; otherwise the latched copy describes it.
  assign rd_word = (state == S_IDLE) ? adr1[AW+1:2] : lat_word;
  assign rd_we   = (state == S_IDLE) ? we1 : lat_we;

  // Next-state logic: accept in IDLE, count wait states, single ack cycle.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    latch_en  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (req1) begin
          latch_en  = 1'b1;
          wcnt_nxt  = 4'd0;
          state_nxt = (WAIT_STATES > 0) ? S_WAIT : S_ACK;
        end
      end
      S_WAIT: begin
        if (!req1) begin
          state_nxt = S_IDLE;
          wcnt_nxt  = 4'd0;
        end else if (wcnt == WS_LAST) begin
          state_nxt = S_ACK;
          wcnt_nxt  = 4'd0;
        end else begin
          wcnt_nxt = wcnt + 4'd1;
        end
      end
      S_ACK: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        wcnt_nxt  = 4'd0;
      end
    endcase
  end

  // State register plus registered ack and read data, both valid only in the ACK cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      wcnt  <= 4'd0;
      ack_o <= 1'b0;
      dat_o <= 32'h0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      ack_o <= (state_nxt == S_ACK);
      dat_o <= ((state_nxt == S_ACK) && !rd_we) ? mem[rd_word] : 32'h0;
    end
  end

  // Capture CPU1's request when it is accepted.
  always_ff @(posedge clk_i) begin
    if (latch_en) begin
      lat_word <= adr1[AW+1:2];
      lat_we   <= we1;
      lat_sel  <= sel1;
      lat_dat  <= dat1;
    end
  end

  // RAM write at the edge that ends the ack cycle; a reset on that edge cancels it.
  always_ff @(posedge clk_i) begin
    if (!rst_i && (state == S_ACK) && lat_we) begin
      for (int b = 0; b < 4; b++) begin
        if (lat_sel[b]) mem[lat_word][8*b +: 8] <= lat_dat[8*b +: 8];
      end
    end
  end

  // Lockstep comparison; write data only matters while CPU1 is writing.
  assign mismatch = (cyc1 | cyc2) &
                    ((cyc1 != cyc2) | (stb1 != stb2) | (we1 != we2) |
                     (sel1 != sel2) | (adr1 != adr2) | (we1 & (dat1 != dat2)));

  // Sticky failure flag with the CPU1 address of the first divergence.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fail     <= 1'b0;
      fail_adr <= 32'h0;
    end else if (mismatch && !fail) begin
      fail     <= 1'b1;
      fail_adr <= adr1;
    end
  end

`ifdef LOCKSTEP_ERRCNT_EN
  // Saturating count of cycles with a detected mismatch.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_cnt <= 16'h0;
    end else if (mismatch && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lockstep_bus_responder.sv
// tb/tb_lockstep_bus_responder.sv - scoreboard bench for lockstep_bus_responder (WAIT_STATES 0 and 3)
module tb_lockstep_bus_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst, cyc1, stb1, cyc2, stb2;
  logic [31:0]      adr1, dat1, adr2, dat2;
  logic             we1, we2;
  logic [3:0]       sel1, sel2;
  logic [1:0]       ack, fail;
  logic [1:0][31:0] rdat, fadr;
`ifdef LOCKSTEP_ERRCNT_EN
  logic [1:0][15:0] ecnt;
`endif

  int checks = 0;
  int errors = 0;
  int ws_of [2] = '{0, 3};
  logic [31:0] adr2_x = 32'h0;
  logic [31:0] dat2_x = 32'h0;
  logic [31:0] model [int];
  logic [31:0] exp_q [$];

  lockstep_bus_responder #(.AW(10), .WAIT_STATES(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst[0]),
    .adr1(adr1), .cyc1(cyc1[0]), .stb1(stb1[0]), .we1(we1), .sel1(sel1), .dat1(dat1),
    .adr2(adr2), .cyc2(cyc2[0]), .stb2(stb2[0]), .we2(we2), .sel2(sel2), .dat2(dat2),
    .ack_o(ack[0]), .dat_o(rdat[0]), .fail(fail[0]), .fail_adr(fadr[0])
`ifdef LOCKSTEP_ERRCNT_EN
    , .err_cnt(ecnt[0])
`endif
  );

  lockstep_bus_responder #(.AW(10), .WAIT_STATES(3)) u_dut1 (
    .clk_i(clk), .rst_i(rst[1]),
    .adr1(adr1), .cyc1(cyc1[1]), .stb1(stb1[1]), .we1(we1), .sel1(sel1), .dat1(dat1),
    .adr2(adr2), .cyc2(cyc2[1]), .stb2(stb2[1]), .we2(we2), .sel2(sel2), .dat2(dat2),
    .ack_o(ack[1]), .dat_o(rdat[1]), .fail(fail[1]), .fail_adr(fadr[1])
`ifdef LOCKSTEP_ERRCNT_EN
    , .err_cnt(ecnt[1])
`endif
  );

  function automatic int key_of(input int d, input logic [31:0] a);
    return d * 65536 + int'((a >> 2) & 32'h3ff);
  endfunction

  task automatic drive(input int d, input logic w, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] wd);
    adr1 = a; we1 = w; sel1 = s; dat1 = wd;
    adr2 = a ^ adr2_x; we2 = w; sel2 = s; dat2 = wd ^ dat2_x;
    cyc1[d] = 1'b1; stb1[d] = 1'b1; cyc2[d] = 1'b1; stb2[d] = 1'b1;
  endtask

  task automatic release_bus(input int d);
    cyc1[d] = 1'b0; stb1[d] = 1'b0; cyc2[d] = 1'b0; stb2[d] = 1'b0;
  endtask

  // One well-behaved access: expectation queued at issue, compared at ack.
  task automatic bus(input int d, input logic w, input logic [31:0] a,
                     input logic [3:0] s, input logic [31:0] wd, output logic [31:0] got);
    int n;
    logic [31:0] expd, m;
    m = 32'h0;
    if (!w) m = model[key_of(d, a)];
    exp_q.push_back(w ? 32'h0 : m);
    drive(d, w, a, s, wd);
    n = 0;
    got = 32'hx;
    do begin
      @(negedge clk);
      n++;
      if (!ack[d]) begin
        checks++;
        if (rdat[d] !== 32'h0) begin
          errors++;
          $display("FAIL dat_idle dut%0d adr=%h got=%h exp=0", d, a, rdat[d]);
        end
      end
    end while (!ack[d] && n < 40);
    checks++;
    if (n !== ws_of[d] + 1) begin
      errors++;
      $display("FAIL latency dut%0d adr=%h got=%0d exp=%0d", d, a, n, ws_of[d] + 1);
    end
    expd = exp_q.pop_front();
    got = rdat[d];
    checks++;
    if (got !== expd) begin
      errors++;
      $display("FAIL ack_data dut%0d adr=%h got=%h exp=%h", d, a, got, expd);
    end
    if (w && ack[d]) begin
      m = model.exists(key_of(d, a)) ? model[key_of(d, a)] : 32'h0;
      for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = wd[8*b +: 8];
      model[key_of(d, a)] = m;
    end
    release_bus(d);
    @(negedge clk);
    checks++;
    if (ack[d] !== 1'b0 || rdat[d] !== 32'h0) begin
      errors++;
      $display("FAIL ack_one_cycle dut%0d got ack=%b dat=%h exp ack=0 dat=0", d, ack[d], rdat[d]);
    end
  endtask

  task automatic test_reset();
    rst = 2'b11;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ack[d] !== 1'b0 || rdat[d] !== 32'h0 || fail[d] !== 1'b0 || fadr[d] !== 32'h0) begin
        errors++;
        $display("FAIL reset dut%0d got ack=%b dat=%h fail=%b fadr=%h exp all 0",
                 d, ack[d], rdat[d], fail[d], fadr[d]);
      end
    end
    rst = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    logic [31:0] got;
    bus(0, 1'b1, 32'h40, 4'hF, 32'hDEADBEEF, got);
    bus(0, 1'b0, 32'h40, 4'hF, 32'h0, got);
    checks++;
    if (got !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL read_40 got=%h exp=deadbeef", got);
    end
    checks++;
    if (fail[0] !== 1'b0) begin
      errors++;
      $display("FAIL no_fail got=%b exp=0", fail[0]);
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] got;
    bus(1, 1'b1, 32'h44, 4'hF, 32'h0BADF00D, got);
    bus(1, 0, 32'h44, 4'hF, 32'h0, got);
    checks++;
    if (got !== 32'h0BADF00D) begin
      errors++;
      $display("FAIL read_44 got=%h exp=0badf00d", got);
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] got;
    bus(0, 1'b1, 32'h80, 4'hF, 32'h11223344, got);
    bus(0, 1'b1, 32'h80, 4'h5, 32'hAABBCCDD, got);
    bus(0, 1'b0, 32'h82, 4'hF, 32'h0, got);
    checks++;
    if (got !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL byte_lanes got=%h exp=11bb33dd", got);
    end
  endtask

  task automatic test_mismatch();
    logic [31:0] got;
    adr2_x = 32'h4;
    bus(0, 1'b1, 32'h100, 4'hF, 32'hCAFEF00D, got);
    checks++;
    if (fail[0] !== 1'b1 || fadr[0] !== 32'h100) begin
      errors++;
      $display("FAIL first_mismatch got fail=%b fadr=%h exp fail=1 fadr=00000100", fail[0], fadr[0]);
    end
    dat2_x = 32'hFFFF_FFFF;
    bus(0, 1'b1, 32'h200, 4'hF, 32'h12345678, got);
    checks++;
    if (fadr[0] !== 32'h100) begin
      errors++;
      $display("FAIL sticky_fadr got=%h exp=00000100", fadr[0]);
    end
    adr2_x = 32'h0;
    dat2_x = 32'h0;
    bus(0, 1'b0, 32'h100, 4'hF, 32'h0, got);
    bus(0, 1'b0, 32'h200, 4'hF, 32'h0, got);
    checks++;
    if (got !== 32'h12345678) begin
      errors++;
      $display("FAIL cpu1_data got=%h exp=12345678", got);
    end
  endtask

  task automatic test_abort();
    logic [31:0] got;
    int n;
    bus(1, 1'b1, 32'h300, 4'hF, 32'h5555AAAA, got);
    drive(1, 1'b1, 32'h300, 4'hF, 32'h77777777);
    @(negedge clk);
    @(negedge clk);
    cyc1[1] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (ack[1] !== 1'b0) begin
        errors++;
        $display("FAIL drop_no_ack cycle %0d got=%b exp=0", i, ack[1]);
      end
    end
    checks++;
    if (fail[1] !== 1'b1 || fadr[1] !== 32'h300) begin
      errors++;
      $display("FAIL drop_fail got fail=%b fadr=%h exp fail=1 fadr=00000300", fail[1], fadr[1]);
    end
    release_bus(1);
    @(negedge clk);
    bus(1, 1'b0, 32'h300, 4'hF, 32'h0, got);
    checks++;
    if (got !== 32'h5555AAAA) begin
      errors++;
      $display("FAIL drop_ram got=%h exp=5555aaaa", got);
    end
    drive(1, 1'b1, 32'h300, 4'hF, 32'h99999999);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack[1] && n < 20);
    checks++;
    if (ack[1] !== 1'b1) begin
      errors++;
      $display("FAIL rst_ack_wait got=%b exp=1", ack[1]);
    end
    rst[1] = 1'b1;
    @(negedge clk);
    checks++;
    if (ack[1] !== 1'b0 || fail[1] !== 1'b0 || fadr[1] !== 32'h0) begin
      errors++;
      $display("FAIL rst_in_ack got ack=%b fail=%b fadr=%h exp 0", ack[1], fail[1], fadr[1]);
    end
    release_bus(1);
    rst[1] = 1'b0;
    @(negedge clk);
    bus(1, 1'b0, 32'h300, 4'hF, 32'h0, got);
    checks++;
    if (got !== 32'h5555AAAA) begin
      errors++;
      $display("FAIL rst_no_write got=%h exp=5555aaaa", got);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] expd;
    logic [2:0] seen;
    exp_q.push_back(model[key_of(0, 32'h40)]);
    exp_q.push_back(model[key_of(0, 32'h40)]);
    drive(0, 1'b0, 32'h40, 4'hF, 32'h0);
    seen = 3'b000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      seen[i] = ack[0];
      if (ack[0] && exp_q.size() > 0) begin
        expd = exp_q.pop_front();
        checks++;
        if (rdat[0] !== expd) begin
          errors++;
          $display("FAIL b2b_data cycle %0d got=%h exp=%h", i, rdat[0], expd);
        end
      end
      if (i == 2) release_bus(0);
    end
    checks++;
    if (seen !== 3'b101) begin
      errors++;
      $display("FAIL b2b_ack_pattern got=%b exp=101", seen);
    end
    while (exp_q.size() > 0) begin
      expd = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL b2b_missing_ack exp=%h", expd);
    end
    @(negedge clk);
  endtask

`ifdef LOCKSTEP_ERRCNT_EN
  task automatic test_errcnt();
    logic [31:0] got;
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    dat2_x = 32'h1;
    for (int i = 0; i < 3; i++) bus(0, 1'b1, 32'h40 + 32'(4 * i), 4'hF, 32'h1000 + 32'(i), got);
    dat2_x = 32'h0;
    checks++;
    if (ecnt[0] !== 16'd3) begin
      errors++;
      $display("FAIL err_cnt_3 got=%0d exp=3", ecnt[0]);
    end
    cyc1[0] = 1'b1;
    repeat (70000) @(negedge clk);
    cyc1[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (ecnt[0] !== 16'hFFFF) begin
      errors++;
      $display("FAIL err_cnt_sat got=%h exp=ffff", ecnt[0]);
    end
  endtask
`endif

  initial begin
    rst = 2'b11;
    cyc1 = 2'b00; stb1 = 2'b00; cyc2 = 2'b00; stb2 = 2'b00;
    adr1 = 32'h0; dat1 = 32'h0; adr2 = 32'h0; dat2 = 32'h0;
    we1 = 1'b0; we2 = 1'b0; sel1 = 4'h0; sel2 = 4'h0;
    test_reset();
    test_write_read();
    test_wait_states();
    test_byte_lanes();
    test_mismatch();
    test_abort();
    test_back_to_back();
`ifdef LOCKSTEP_ERRCNT_EN
    test_errcnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
